reg_bus_arbiter: RTL and testbench
==================================

Name: reg_bus_arbiter

Overview:
Two-requester, round-robin arbiter for the 8-bit register bus driven by the I2C slave's request/response register interface. Lets the I2C slave and a second bus master (e.g. a UART bridge or a local sequencer) share one register decode block. Registers each accepted transaction, forwards it to the target, and returns the response or a timeout error to the owning requester.

Parameters:
ADDRESS_WIDTH, 8, width of the register address.
DATA_WIDTH, 8, width of the read and write data.
TIMEOUT_CYCLES, 16, ACCESS cycles without t_response before an error completion; must be >= 1.

Ports:
clock  input  1  system clock, all logic on its rising edge
reset  input  1  synchronous, active-high reset
m0_request  input  1  requester 0 transaction request; held until m0_response
m0_is_write  input  1  requester 0: 1 = write, 0 = read
m0_address  input  ADDRESS_WIDTH  requester 0 register address
m0_write_data  input  DATA_WIDTH  requester 0 write data
m0_response  output  1  one-cycle completion pulse to requester 0
m0_read_data  output  DATA_WIDTH  read data, valid while m0_response=1
m0_error  output  1  timeout flag, valid while m0_response=1
m1_*  (same seven signals as m0_*, for requester 1)
t_request  output  1  request to the target register block
t_is_write  output  1  latched direction
t_address  output  ADDRESS_WIDTH  latched address
t_write_data  output  DATA_WIDTH  latched write data
t_response  input  1  target acknowledge; may be combinational from t_request
t_read_data  input  DATA_WIDTH  target read data, sampled when t_response=1

Behaviour:
- Reset: state=IDLE, last_grant=1 (m0 wins the first tie). All outputs 0: m*_response, m*_error, m*_read_data, t_request, t_is_write, t_address, t_write_data. Reset mid-transaction aborts it; no response is issued.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Only one mX_request high: grant X.
  - Both high: grant the requester not equal to last_grant.
  - On grant: latch is_write, address and write_data into the t_* registers, clear the timeout counter, go to ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - t_request=1 and t_* fields are stable.
  - t_response=1: capture t_read_data (capture 0 for writes) and set err=0, go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES-1 with no response: read data=0, err=1, go to DONE.
  - Counter width: $clog2(TIMEOUT_CYCLES+1).
- DONE:
  - t_request=0.
  - The granted mX_response=1 for exactly one cycle, with mX_read_data and mX_error.
  - last_grant <= granted index; go to IDLE.
  - The non-granted requester's outputs stay 0.
- m*_read_data and m*_error are 0 in every cycle where m*_response=0.
- Latency: request sampled in IDLE at cycle N, t_request high at N+1. With a combinational target, mX_response is at N+2, so the minimum request-to-response time is 2 cycles.
- Handshake: a requester keeps its fields stable while its request is high and deasserts request the cycle after it samples response. A request still high in the IDLE cycle after DONE is treated as a new transaction.
- Changes on mX_* inputs after the grant are ignored; fields are latched.
- t_response while t_request=0 (IDLE or DONE) is ignored.
- Late t_response arriving in the DONE cycle after a timeout is ignored; the target must tolerate the dropped request.
- Fairness: with both requesters continuously requesting, grants strictly alternate. Neither requester waits more than one transaction.

Test Plan:
- Reset then m0 read addr 0x00, target responds combinationally with 0xA5 -> t_request at cycle 1; m0_response pulse at cycle 2 with m0_read_data=0xA5 and m0_error=0; m1 outputs stay 0.
- m1 write addr 0x01 data 0x3C, target response delayed 3 cycles -> t_address=0x01 and t_write_data=0x3C held for 4 cycles; single m1_response pulse with read_data=0x00 and error=0.
- m0 and m1 both request in the same cycle from reset, three transactions each -> grant order m0, m1, m0, m1, m0, m1; each requester gets exactly three responses.
- TIMEOUT_CYCLES=16, target never responds to an m0 read -> t_request high for 16 cycles; m0_response with m0_error=1 and m0_read_data=0x00; FSM back to IDLE, and the next m1 request is served normally.
- Reset asserted during ACCESS of an m1 read -> t_request=0 next cycle and no m1_response; after reset release a tie is granted to m0.
- Target asserts t_response while idle, and m0 changes m0_address mid-ACCESS -> no spurious m*_response; t_address keeps the originally latched value.

Source files
------------

// File: rtl/reg_bus_arbiter.sv
// Two-requester round-robin arbiter in front of a shared register target.
// Each accepted transaction is latched, forwarded, and completed with data or a timeout error.
module reg_bus_arbiter #(
   parameter int ADDRESS_WIDTH  = 8,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   // requester 0
   input  logic                     m0_request,
   input  logic                     m0_is_write,
   input  logic [ADDRESS_WIDTH-1:0] m0_address,
   input  logic [DATA_WIDTH-1:0]    m0_write_data,
   output logic                     m0_response,
   output logic [DATA_WIDTH-1:0]    m0_read_data,
   output logic                     m0_error,
   // requester 1
   input  logic                     m1_request,
   input  logic                     m1_is_write,
   input  logic [ADDRESS_WIDTH-1:0] m1_address,
   input  logic [DATA_WIDTH-1:0]    m1_write_data,
   output logic                     m1_response,
   output logic [DATA_WIDTH-1:0]    m1_read_data,
   output logic                     m1_error,
   // target
   output logic                     t_request,
   output logic                     t_is_write,
   output logic [ADDRESS_WIDTH-1:0] t_address,
   output logic [DATA_WIDTH-1:0]    t_write_data,
   input  logic                     t_response,
   input  logic [DATA_WIDTH-1:0]    t_read_data,
   // debug: current FSM state (0 = IDLE, 1 = ACCESS, 2 = DONE)
   output logic [1:0]               dbg_state
);

   // Handshake: a requester holds mX_request and its fields stable until it
   // sees the one-cycle mX_response; the target sees t_request high with
   // stable t_* fields until it answers with t_response (or the timeout fires).

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t                     r_state;
   logic                       r_last_grant;
   logic                       r_grant;
   logic [CW-1:0]              r_count;

   logic                       r_t_request;
   logic                       r_t_is_write;
   logic [ADDRESS_WIDTH-1:0]   r_t_address;
   logic [DATA_WIDTH-1:0]      r_t_write_data;

   logic                       r_m0_response;
   logic [DATA_WIDTH-1:0]      r_m0_read_data;
   logic                       r_m0_error;
   logic                       r_m1_response;
   logic [DATA_WIDTH-1:0]      r_m1_read_data;
   logic                       r_m1_error;

   logic                       w_any_request;
   logic                       w_grant_idx;
   logic                       w_sel_is_write;
   logic [ADDRESS_WIDTH-1:0]   w_sel_address;
   logic [DATA_WIDTH-1:0]      w_sel_write_data;
   logic                       w_finish;
   logic [DATA_WIDTH-1:0]      w_done_data;
   logic                       w_done_error;

   // On a tie the requester that did not win last time is chosen.
   always_comb begin
      w_any_request = m0_request | m1_request;
      if (m0_request && m1_request) begin
         w_grant_idx = ~r_last_grant;
      end else begin
         w_grant_idx = m1_request;
      end
      w_sel_is_write   = w_grant_idx ? m1_is_write   : m0_is_write;
      w_sel_address    = w_grant_idx ? m1_address    : m0_address;
      w_sel_write_data = w_grant_idx ? m1_write_data : m0_write_data;
   end

   // Completion payload: target data for reads, zero for writes and timeouts.
   always_comb begin
      w_finish     = t_response || (r_count == LAST_COUNT);
      w_done_error = ~t_response;
      if (t_response && !r_t_is_write) begin
         w_done_data = t_read_data;
      end else begin
         w_done_data = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state        <= IDLE;
         r_last_grant   <= 1'b1;
         r_grant        <= 1'b0;
         r_count        <= '0;
         r_t_request    <= 1'b0;
         r_t_is_write   <= 1'b0;
         r_t_address    <= '0;
         r_t_write_data <= '0;
         r_m0_response  <= 1'b0;
         r_m0_read_data <= '0;
         r_m0_error     <= 1'b0;
         r_m1_response  <= 1'b0;
         r_m1_read_data <= '0;
         r_m1_error     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any_request) begin
                  r_grant        <= w_grant_idx;
                  r_t_is_write   <= w_sel_is_write;
                  r_t_address    <= w_sel_address;
                  r_t_write_data <= w_sel_write_data;
                  r_count        <= '0;
                  r_t_request    <= 1'b1;
                  r_state        <= ACCESS;
               end
            end

            ACCESS: begin
               if (w_finish) begin
                  r_t_request <= 1'b0;
                  r_state     <= DONE;
                  if (r_grant) begin
                     r_m1_response  <= 1'b1;
                     r_m1_read_data <= w_done_data;
                     r_m1_error     <= w_done_error;
                  end else begin
                     r_m0_response  <= 1'b1;
                     r_m0_read_data <= w_done_data;
                     r_m0_error     <= w_done_error;
                  end
               end else begin
                  r_count <= r_count + 1'b1;
               end
            end

            DONE: begin
               // A late t_response here is deliberately not looked at.
               r_m0_response  <= 1'b0;
               r_m0_read_data <= '0;
               r_m0_error     <= 1'b0;
               r_m1_response  <= 1'b0;
               r_m1_read_data <= '0;
               r_m1_error     <= 1'b0;
               r_last_grant   <= r_grant;
               r_state        <= IDLE;
            end

            default: begin
               r_t_request <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign t_request    = r_t_request;
   assign t_is_write   = r_t_is_write;
   assign t_address    = r_t_address;
   assign t_write_data = r_t_write_data;

   assign m0_response  = r_m0_response;
   assign m0_read_data = r_m0_read_data;
   assign m0_error     = r_m0_error;
   assign m1_response  = r_m1_response;
   assign m1_read_data = r_m1_read_data;
   assign m1_error     = r_m1_error;

   assign dbg_state    = r_state;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboarded bench for reg_bus_arbiter: directed scenarios then randomized traffic
// against a target model whose read data is address ^ 0xA5 and which never answers 0xF0-0xFF.
module tb_reg_bus_arbiter;

   logic       clock = 1'b0;
   logic       reset;
   logic       req   [2];
   logic       is_wr [2];
   logic [7:0] addr  [2];
   logic [7:0] wdata [2];
   logic       resp  [2];
   logic [7:0] rdata [2];
   logic       err   [2];
   logic       t_request, t_is_write, t_response;
   logic [7:0] t_address, t_write_data, t_read_data;
   logic [1:0] dbg_state;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   reg_bus_arbiter #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
      .clock(clock), .reset(reset),
      .m0_request(req[0]), .m0_is_write(is_wr[0]), .m0_address(addr[0]),
      .m0_write_data(wdata[0]), .m0_response(resp[0]), .m0_read_data(rdata[0]),
      .m0_error(err[0]),
      .m1_request(req[1]), .m1_is_write(is_wr[1]), .m1_address(addr[1]),
      .m1_write_data(wdata[1]), .m1_response(resp[1]), .m1_read_data(rdata[1]),
      .m1_error(err[1]),
      .t_request(t_request), .t_is_write(t_is_write), .t_address(t_address),
      .t_write_data(t_write_data), .t_response(t_response), .t_read_data(t_read_data),
      .dbg_state(dbg_state)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Target model: answers after tgt_delay cycles of t_request (0 = same cycle).
   int   tgt_seen     = 0;
   int   tgt_delay    = 0;
   int   forced_delay = -1;
   logic spur         = 1'b0;

   assign t_response  = spur | (t_request && (t_address < 8'hF0) && (tgt_seen > tgt_delay));
   assign t_read_data = t_address ^ 8'hA5;

   always @(negedge clock) begin
      if (!t_request) begin
         tgt_seen  = 0;
         tgt_delay = (forced_delay >= 0) ? forced_delay : int'($urandom_range(0, 4));
      end else begin
         tgt_seen++;
      end
   end

   // Scoreboard state
   logic [8:0]  exp_q0 [$];
   logic [8:0]  exp_q1 [$];
   int          grant_log [$];
   logic        busy [2];
   logic [16:0] cur_fields [2];
   int          treq_run = 0, last_run = 0, treq_rise_cyc = 0;
   logic [7:0]  last_taddr, last_twdata;

   always @(negedge clock) begin : monitor
      logic [8:0] got, e;
      logic       match;
      if (t_request) begin
         if (treq_run == 0) treq_rise_cyc = cyc;
         treq_run++;
         last_taddr  = t_address;
         last_twdata = t_write_data;
      end else if (treq_run > 0) begin
         last_run = treq_run;
         treq_run = 0;
      end
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            if (resp[i]) begin
               got = {err[i], rdata[i]};
               if (i == 0) begin
                  check("m0_resp_has_expectation", exp_q0.size() > 0, 1);
                  if (exp_q0.size() > 0) begin
                     e = exp_q0.pop_front();
                     check("m0_response_payload", got, e);
                  end
               end else begin
                  check("m1_resp_has_expectation", exp_q1.size() > 0, 1);
                  if (exp_q1.size() > 0) begin
                     e = exp_q1.pop_front();
                     check("m1_response_payload", got, e);
                  end
               end
               grant_log.push_back(i);
            end else begin
               check("quiet_outputs_zero", {err[i], rdata[i]}, 0);
            end
         end
         check("single_response", resp[0] & resp[1], 0);
         if (t_request) begin
            match = (busy[0] && {t_is_write, t_address, t_write_data} == cur_fields[0]) ||
                    (busy[1] && {t_is_write, t_address, t_write_data} == cur_fields[1]);
            check("t_fields_latched", match, 1);
         end
      end
   end

   // Driver: issue one transaction, push its expected completion, wait for it.
   task automatic do_txn(input int i, input logic w, input logic [7:0] a,
                         input logic [7:0] d, output int lat, output int c_issue);
      logic [8:0] e;
      bit         got;
      @(posedge clock); #1;
      req[i] = 1'b1; is_wr[i] = w; addr[i] = a; wdata[i] = d;
      cur_fields[i] = {w, a, d};
      busy[i] = 1'b1;
      if (a >= 8'hF0)  e = 9'h100;
      else if (w)      e = 9'h000;
      else             e = {1'b0, a ^ 8'hA5};
      if (i == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
      c_issue = cyc;
      got = 1'b0;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clock);
         if (resp[i]) got = 1'b1;
      end
      check("response_within_bound", got, 1);
      lat = cyc - c_issue;
      req[i]  = 1'b0;
      busy[i] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int lat, ci, lat1, ci1;
      bit seen;
      for (int i = 0; i < 2; i++) begin
         req[i] = 0; is_wr[i] = 0; addr[i] = 0; wdata[i] = 0; busy[i] = 0; cur_fields[i] = 0;
      end
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset_t_request", t_request, 0);
      check("reset_t_fields", {t_is_write, t_address, t_write_data}, 0);
      check("reset_m0_outputs", {resp[0], err[0], rdata[0]}, 0);
      check("reset_m1_outputs", {resp[1], err[1], rdata[1]}, 0);
      check("reset_state_idle", dbg_state, 0);
      @(posedge clock); #1 reset = 1'b0;

      // m0 read 0x00, combinational target
      forced_delay = 0;
      do_txn(0, 1'b0, 8'h00, 8'h00, lat, ci);
      @(negedge clock);
      check("min_latency", lat, 2);
      check("t_request_rise_cycle", treq_rise_cyc - ci, 1);
      check("comb_access_length", last_run, 1);

      // m1 write 0x01/0x3C, target answers after 3 extra cycles
      forced_delay = 3;
      do_txn(1, 1'b1, 8'h01, 8'h3C, lat, ci);
      @(negedge clock);
      check("delayed_access_length", last_run, 4);
      check("delayed_t_address", last_taddr, 8'h01);
      check("delayed_t_write_data", last_twdata, 8'h3C);

      // timeout on m0 read, then m1 served normally
      forced_delay = -1;
      do_txn(0, 1'b0, 8'hF3, 8'h00, lat, ci);
      @(negedge clock);
      check("timeout_access_length", last_run, 16);
      check("timeout_back_to_idle", dbg_state, 0);
      do_txn(1, 1'b0, 8'h10, 8'h00, lat, ci);

      // stray t_response while idle, and m0 address change mid-access
      @(posedge clock); #1 spur = 1'b1;
      repeat (3) @(posedge clock);
      #1 spur = 1'b0;
      forced_delay = 3;
      fork
         do_txn(0, 1'b0, 8'h20, 8'h00, lat, ci);
         begin
            seen = 0;
            for (int k = 0; k < 20 && !seen; k++) begin
               @(negedge clock);
               if (t_request) seen = 1;
            end
            check("access_started", seen, 1);
            addr[0] = 8'h77;
         end
      join
      @(negedge clock);
      check("address_kept_latched", last_taddr, 8'h20);
      forced_delay = -1;

      // reset during an m1 access to a silent address
      @(posedge clock); #1;
      req[1] = 1'b1; is_wr[1] = 1'b0; addr[1] = 8'hF5; wdata[1] = 8'h00;
      cur_fields[1] = {1'b0, 8'hF5, 8'h00};
      busy[1] = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("treq_before_reset", t_request, 1);
      @(posedge clock); #1 reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check("treq_cleared_by_reset", t_request, 0);
      check("no_m1_response_on_reset", resp[1], 0);
      req[1] = 1'b0; busy[1] = 1'b0;
      @(posedge clock); #1 reset = 1'b0;

      // simultaneous requesters, three transactions each
      grant_log.delete();
      fork
         for (int n = 0; n < 3; n++)
            do_txn(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 8'hEF)), 8'($urandom), lat, ci);
         for (int n = 0; n < 3; n++)
            do_txn(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 8'hEF)), 8'($urandom), lat1, ci1);
      join
      @(negedge clock);
      check("tie_grant_count", grant_log.size(), 6);
      for (int n = 0; n < grant_log.size(); n++)
         check($sformatf("tie_grant_order_%0d", n), grant_log[n], n % 2);

      // randomized traffic with idle gaps
      fork
         for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clock);
            do_txn(0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), lat, ci);
         end
         for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clock);
            do_txn(1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), lat1, ci1);
         end
      join
      repeat (4) @(negedge clock);
      check("m0_queue_drained", exp_q0.size(), 0);
      check("m1_queue_drained", exp_q1.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
